// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and its downstream decoder.
// The optional auto-repeat feature lives in keypad_scanner, behind KEYPAD_SCAN_REPEAT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam logic [3:0] COL_FIRST = 4'b0001;

    // Exactly one bit set; zero or multiple rows means no key or a ghost.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [3:0] next_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with per-sample debounce of press and release.
// Define KEYPAD_SCAN_REPEAT_EN to emit repeat strobes while a key is held.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | rotating column drive, waiting for a single-row sample
// DEBOUNCE | column frozen, counting samples that match the candidate
// HELD     | key accepted, counting non-matching samples toward release
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DIV   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic       key_strobe
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int MW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] CNT_LAST  = MW'(DEBOUNCE_CNT - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DIV < 1) begin : g_param_check
        $error("keypad_scanner: invalid parameter set");
    end

    logic [3:0]    row_s;
    logic [DW-1:0] dcnt;
    logic          sample;
    state_t        state;
    logic [3:0]    cand_row;
    logic [3:0]    cand_col;
    logic [MW-1:0] mcnt;
    logic [MW-1:0] rcnt;

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int RW = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DIV - 1);
    logic [RW-1:0] rep;
`endif

    sync_2ff #(.W(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (row_s)
    );

    assign sample = (dcnt == DCNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
        end else if (sample) begin
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

    // All decisions are taken only on the last cycle of a dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCAN;
            col_drive  <= COL_FIRST;
            cand_row   <= 4'b0000;
            cand_col   <= 4'b0000;
            mcnt       <= '0;
            rcnt       <= '0;
            row        <= 4'b0000;
            col        <= 4'b0000;
            key_valid  <= 1'b0;
            key_strobe <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rep        <= '0;
`endif
        end else begin
            key_strobe <= 1'b0;
            if (sample) begin
                unique case (state)
                    SCAN: begin
                        if (is_onehot(row_s)) begin
                            cand_row <= row_s;
                            cand_col <= col_drive;
                            if (DEBOUNCE_CNT == 1) begin
                                row        <= row_s;
                                col        <= col_drive;
                                key_valid  <= 1'b1;
                                key_strobe <= 1'b1;
                                rcnt       <= '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                                rep        <= '0;
`endif
                                state      <= HELD;
                            end else begin
                                mcnt  <= MW'(1);
                                state <= DEBOUNCE;
                            end
                        end else begin
                            col_drive <= next_col(col_drive);
                        end
                    end

                    DEBOUNCE: begin
                        if (row_s == cand_row) begin
                            if (mcnt == CNT_LAST) begin
                                row        <= cand_row;
                                col        <= cand_col;
                                key_valid  <= 1'b1;
                                key_strobe <= 1'b1;
                                mcnt       <= '0;
                                rcnt       <= '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                                rep        <= '0;
`endif
                                state      <= HELD;
                            end else begin
                                mcnt <= mcnt + MW'(1);
                            end
                        end else begin
                            mcnt      <= '0;
                            col_drive <= next_col(col_drive);
                            state     <= SCAN;
                        end
                    end

                    HELD: begin
                        if (row_s == row) begin
                            rcnt <= '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                            if (rep == REP_LAST) begin
                                key_strobe <= 1'b1;
                                rep        <= '0;
                            end else begin
                                rep <= rep + RW'(1);
                            end
`endif
                        end else begin
`ifdef KEYPAD_SCAN_REPEAT_EN
                            rep <= '0;
`endif
                            if (rcnt == CNT_LAST) begin
                                rcnt      <= '0;
                                key_valid <= 1'b0;
                                col_drive <= next_col(col_drive);
                                state     <= SCAN;
                            end else begin
                                rcnt <= rcnt + MW'(1);
                            end
                        end
                    end

                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DIV=2.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_row = 4'b0000;
    logic [3:0] key_col = 4'b0000;
    logic       bounce = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic       key_strobe;

    int vectors = 0;
    int miscompares = 0;
    int strobe_total = 0;
    int base = 0;

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int EXP_HOLD_STROBES = 6;
    localparam logic EXP_REP_AT_24 = 1'b1;
`else
    localparam int EXP_HOLD_STROBES = 1;
    localparam logic EXP_REP_AT_24 = 1'b0;
`endif

    // Keypad model: the pressed key connects its row to its column drive.
    assign row_in = (!bounce && ((col_drive & key_col) != 4'b0000)) ? key_row : 4'b0000;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (key_strobe === 1'b1) strobe_total <= strobe_total + 1;
    end

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3),
        .REPEAT_DIV   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_in     (row_in),
        .col_drive  (col_drive),
        .row        (row),
        .col        (col),
        .key_valid  (key_valid),
        .key_strobe (key_strobe)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ends on the negedge where reset is released; the next posedge is edge 1.
    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = strobe_total;
    endtask

    initial begin
        // Reset values and idle rotation
        reset_dut();
        chk("rst_col_drive", col_drive, 4'b0001);
        chk("rst_row", row, 4'b0000);
        chk("rst_col", col, 4'b0000);
        chk("rst_valid", {3'b000, key_valid}, 4'b0000);
        chk("rst_strobe", {3'b000, key_strobe}, 4'b0000);
        step(3);
        chk("rot_edge3", col_drive, 4'b0001);
        step(1);
        chk("rot_edge4", col_drive, 4'b0010);
        step(4);
        chk("rot_edge8", col_drive, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_col_drive", col_drive, 4'b0001);
        chk("async_rst_valid", {3'b000, key_valid}, 4'b0000);

        // Clean press of key "5" (row 0010, column 0010), then release
        key_row = 4'b0010;
        key_col = 4'b0010;
        reset_dut();
        step(12);
        chk("press_col_frozen", col_drive, 4'b0010);
        chk("press_not_yet_valid", {3'b000, key_valid}, 4'b0000);
        step(3);
        chk("press_edge15_strobe", {3'b000, key_strobe}, 4'b0000);
        step(1);
        chk("press_strobe", {3'b000, key_strobe}, 4'b0001);
        chk("press_valid", {3'b000, key_valid}, 4'b0001);
        chk("press_row", row, 4'b0010);
        chk("press_col", col, 4'b0010);
        step(1);
        chk("press_strobe_1cyc", {3'b000, key_strobe}, 4'b0000);
        chk("press_valid_held", {3'b000, key_valid}, 4'b0001);
        key_row = 4'b0000;
        step(10);
        chk("release_edge27_valid", {3'b000, key_valid}, 4'b0001);
        chk("release_edge27_col", col_drive, 4'b0010);
        step(1);
        chk("release_valid", {3'b000, key_valid}, 4'b0000);
        chk("release_col_next", col_drive, 4'b0100);
        chk("release_row_kept", row, 4'b0010);
        chk("release_col_kept", col, 4'b0010);
        chk_int("press_strobe_count", strobe_total - base, 1);

        // Bounce during DEBOUNCE: one bad sample returns to SCAN
        key_row = 4'b0010;
        key_col = 4'b0010;
        reset_dut();
        step(9);
        bounce = 1'b1;
        step(1);
        bounce = 1'b0;
        step(2);
        chk("bounce_rescan_col", col_drive, 4'b0100);
        chk("bounce_no_valid", {3'b000, key_valid}, 4'b0000);
        step(23);
        chk("bounce_edge35_strobe", {3'b000, key_strobe}, 4'b0000);
        chk_int("bounce_no_strobe", strobe_total - base, 0);
        step(1);
        chk("bounce_accept_strobe", {3'b000, key_strobe}, 4'b0001);
        chk("bounce_accept_valid", {3'b000, key_valid}, 4'b0001);
        chk("bounce_accept_row", row, 4'b0010);
        chk("bounce_accept_col", col, 4'b0010);

        // Ghost: two rows on one column are never captured
        key_row = 4'b0110;
        key_col = 4'b0100;
        reset_dut();
        step(12);
        chk("ghost_col_edge12", col_drive, 4'b1000);
        chk("ghost_no_valid", {3'b000, key_valid}, 4'b0000);
        step(4);
        chk("ghost_col_edge16", col_drive, 4'b0001);
        step(14);
        chk("ghost_col_edge30", col_drive, 4'b1000);
        chk_int("ghost_no_strobe", strobe_total - base, 0);

        // Reset while HELD, then re-acceptance and hold/repeat behaviour
        key_row = 4'b0010;
        key_col = 4'b0010;
        reset_dut();
        step(20);
        chk("held_valid", {3'b000, key_valid}, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("held_rst_valid", {3'b000, key_valid}, 4'b0000);
        chk("held_rst_row", row, 4'b0000);
        chk("held_rst_col", col, 4'b0000);
        chk("held_rst_col_drive", col_drive, 4'b0001);
        reset_dut();
        step(15);
        chk("rehit_edge15_strobe", {3'b000, key_strobe}, 4'b0000);
        step(1);
        chk("rehit_strobe", {3'b000, key_strobe}, 4'b0001);
        step(8);
        chk("repeat_edge24_strobe", {3'b000, key_strobe}, {3'b000, EXP_REP_AT_24});
        step(33);
        key_row = 4'b0000;
        step(10);
        chk("hold_release_edge67", {3'b000, key_valid}, 4'b0001);
        step(3);
        chk("hold_release_valid", {3'b000, key_valid}, 4'b0000);
        chk_int("hold_strobe_count", strobe_total - base, EXP_HOLD_STROBES);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
